// File: rtl/sr_drive_ctrl_if.sv
// Button requests into sr_drive_ctrl and the active-low latch drive / status strobes out of it.
// The master drives the buttons. The slave (the controller) drives the latch inputs and the status.
interface sr_drive_ctrl_if;
  logic set_btn;
  logic rst_btn;
  logic S;
  logic R;
  logic busy;
  logic conflict;
  logic dropped;

  modport master (
    output set_btn,
    output rst_btn,
    input  S,
    input  R,
    input  busy,
    input  conflict,
    input  dropped
  );

  modport slave (
    input  set_btn,
    input  rst_btn,
    output S,
    output R,
    output busy,
    output conflict,
    output dropped
  );
endinterface

// File: rtl/sr_drive_ctrl.sv
// Front-end for a NAND SR latch: synchronise and debounce two buttons, then turn each press into
// a fixed-width active-low S or R pulse. S and R are never low at the same time.
module sr_drive_ctrl #(
  parameter int DB_CNT    = 4,
  parameter int PULSE_LEN = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sr_drive_ctrl_if.slave bus
);

  localparam int DB_W = $clog2(DB_CNT + 1);
  localparam int PL_W = $clog2(PULSE_LEN + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);
  localparam logic [PL_W-1:0] PL_LAST = PL_W'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    RST_P = 2'd2,
    GUARD = 2'd3
  } state_t;

  // Channel 0 is the set button and channel 1 is the reset button.
  logic [1:0]      btn_s;
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0]      db_r;
  logic [1:0]      db_prev_r;
  logic [DB_W-1:0] db_cnt_r [2];
  logic [1:0]      press_s;

  state_t          state_r;
  state_t          next_state_s;
  logic [PL_W-1:0] pcnt_r;
  logic [PL_W-1:0] pcnt_next_s;
  logic            conflict_next_s;
  logic            dropped_next_s;

  logic            s_r;
  logic            r_r;
  logic            busy_r;
  logic            conflict_r;
  logic            dropped_r;

  assign btn_s = {bus.rst_btn, bus.set_btn};

  // Synchronise both buttons. A level change is accepted only after DB_CNT stable samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r   <= 2'b00;
      sync2_r   <= 2'b00;
      db_r      <= 2'b00;
      db_prev_r <= 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        db_cnt_r[ch] <= {DB_W{1'b0}};
      end
    end else begin
      sync1_r   <= btn_s;
      sync2_r   <= sync1_r;
      db_prev_r <= db_r;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2_r[ch] != db_r[ch]) begin
          if (db_cnt_r[ch] == DB_LAST) begin
            db_r[ch]     <= sync2_r[ch];
            db_cnt_r[ch] <= {DB_W{1'b0}};
          end else begin
            db_cnt_r[ch] <= db_cnt_r[ch] + DB_W'(1);
          end
        end else begin
          db_cnt_r[ch] <= {DB_W{1'b0}};
        end
      end
    end
  end

  // A press is the single cycle in which the debounced level rises.
  assign press_s = db_r & ~db_prev_r;

  // Next-state and strobe decode. Presses arriving outside IDLE are discarded, not queued.
  always_comb begin
    next_state_s    = state_r;
    pcnt_next_s     = pcnt_r;
    conflict_next_s = 1'b0;
    dropped_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        pcnt_next_s = {PL_W{1'b0}};
        if (press_s == 2'b11) begin
          conflict_next_s = 1'b1;
        end else if (press_s == 2'b01) begin
          next_state_s = SET_P;
        end else if (press_s == 2'b10) begin
          next_state_s = RST_P;
        end else begin
          next_state_s = IDLE;
        end
      end
      SET_P, RST_P: begin
        dropped_next_s = |press_s;
        if (pcnt_r == PL_LAST) begin
          next_state_s = GUARD;
          pcnt_next_s  = {PL_W{1'b0}};
        end else begin
          pcnt_next_s  = pcnt_r + PL_W'(1);
        end
      end
      GUARD: begin
        dropped_next_s = |press_s;
        next_state_s   = IDLE;
      end
      default: begin
        next_state_s = IDLE;
        pcnt_next_s  = {PL_W{1'b0}};
      end
    endcase
  end

  // State and outputs are registered together. S and R are each decoded from exactly one state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pcnt_r     <= {PL_W{1'b0}};
      s_r        <= 1'b1;
      r_r        <= 1'b1;
      busy_r     <= 1'b0;
      conflict_r <= 1'b0;
      dropped_r  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      pcnt_r     <= pcnt_next_s;
      s_r        <= (next_state_s != SET_P);
      r_r        <= (next_state_s != RST_P);
      busy_r     <= (next_state_s != IDLE);
      conflict_r <= conflict_next_s;
      dropped_r  <= dropped_next_s;
    end
  end

  assign bus.S        = s_r;
  assign bus.R        = r_r;
  assign bus.busy     = busy_r;
  assign bus.conflict = conflict_r;
  assign bus.dropped  = dropped_r;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: directed scenarios followed by random button activity. Every output is
// compared each cycle against a model built on the sample history of each button.
`timescale 1ns/1ps
module tb_sr_drive_ctrl;
  localparam int DB_CNT    = 4;
  localparam int PULSE_LEN = 2;
  localparam int MAXE      = 4096;

  logic clk = 1'b0;
  logic rst_n;

  sr_drive_ctrl_if bus ();

  sr_drive_ctrl #(.DB_CNT(DB_CNT), .PULSE_LEN(PULSE_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: the raw sample taken at each edge, the debounced levels, and the current pulse.
  bit hist [2][MAXE];
  int edge_n   = 0;
  int last_rst = -1;
  bit db_m     [2];
  bit db_old_m [2];
  int kind     = 0;
  int p_start  = 0;
  bit exp_s = 1'b1, exp_r = 1'b1, exp_busy = 1'b0, exp_conf = 1'b0, exp_drop = 1'b0;

  int s_low, r_low, busy_cnt, conf_cnt, drop_cnt, first_s, first_r;

  // The debouncer at edge m sees the raw sample taken two edges earlier.
  function automatic bit seen(input int ch, input int m);
    if (m - 2 < 0) return 1'b0;
    return hist[ch][m-2];
  endfunction

  task automatic model_edge(input bit rn, input bit sb, input bit rb);
    bit pr [2];
    bit busy_prev, all_eq, v;
    int n;
    n = edge_n;
    if (!rn) begin
      for (int ch = 0; ch < 2; ch++) begin
        hist[ch][n] = 1'b0;
        if (n > 0) hist[ch][n-1] = 1'b0;
        db_m[ch] = 1'b0;
        db_old_m[ch] = 1'b0;
      end
      last_rst = n;
      kind = 0;
      exp_s = 1'b1; exp_r = 1'b1; exp_busy = 1'b0; exp_conf = 1'b0; exp_drop = 1'b0;
    end else begin
      hist[0][n] = sb;
      hist[1][n] = rb;
      for (int ch = 0; ch < 2; ch++) begin
        pr[ch] = db_m[ch] & ~db_old_m[ch];
        db_old_m[ch] = db_m[ch];
        if (n - DB_CNT + 1 > last_rst) begin
          v = seen(ch, n);
          all_eq = 1'b1;
          for (int k = 0; k < DB_CNT; k++) if (seen(ch, n - k) != v) all_eq = 1'b0;
          if (all_eq && (v != db_m[ch])) db_m[ch] = v;
        end
      end
      busy_prev = (kind != 0) && (n - 1 >= p_start) && (n - 1 <= p_start + PULSE_LEN);
      exp_conf = 1'b0;
      exp_drop = 1'b0;
      if (pr[0] | pr[1]) begin
        if (busy_prev) exp_drop = 1'b1;
        else if (pr[0] & pr[1]) exp_conf = 1'b1;
        else begin
          kind = pr[0] ? 1 : 2;
          p_start = n;
        end
      end
      exp_busy = (kind != 0) && (n >= p_start) && (n <= p_start + PULSE_LEN);
      exp_s = !((kind == 1) && (n >= p_start) && (n < p_start + PULSE_LEN));
      exp_r = !((kind == 2) && (n >= p_start) && (n < p_start + PULSE_LEN));
    end
    edge_n++;
  endtask

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, expv, edge_n - 1);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs == expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clr();
    s_low = 0; r_low = 0; busy_cnt = 0; conf_cnt = 0; drop_cnt = 0;
    first_s = -1; first_r = -1;
  endtask

  // Apply one input pair for one clock, advance the model, then check all outputs mid-cycle.
  task automatic step(input bit sb, input bit rb);
    bus.set_btn = sb;
    bus.rst_btn = rb;
    @(posedge clk);
    model_edge(rst_n, sb, rb);
    @(negedge clk);
    chk("S", bus.S, exp_s);
    chk("R", bus.R, exp_r);
    chk("busy", bus.busy, exp_busy);
    chk("conflict", bus.conflict, exp_conf);
    chk("dropped", bus.dropped, exp_drop);
    chk("S_R_not_both_low", bus.S | bus.R, 1'b1);
    if (bus.S === 1'b0) begin s_low++; if (first_s < 0) first_s = edge_n - 1; end
    if (bus.R === 1'b0) begin r_low++; if (first_r < 0) first_r = edge_n - 1; end
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.conflict === 1'b1) conf_cnt++;
    if (bus.dropped === 1'b1) drop_cnt++;
  endtask

  initial begin
    int e0;
    bit sb, rb;
    int len;
    rst_n = 1'b0;
    bus.set_btn = 1'b0;
    bus.rst_btn = 1'b0;

    // Reset held for three cycles while both buttons toggle.
    for (int i = 0; i < 3; i++) step(i[0] ? 1'b0 : 1'b1, i[0] ? 1'b1 : 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

    // A clean set press, then release.
    clr();
    e0 = edge_n;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    chk_int("clean_S_first_low_edge", first_s, e0 + DB_CNT + 2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk_int("clean_S_low_cycles", s_low, PULSE_LEN);
    chk_int("clean_busy_cycles", busy_cnt, PULSE_LEN + 1);
    chk_int("clean_R_low_cycles", r_low, 0);

    // A bouncing reset button that then stays high.
    clr();
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0);
    e0 = edge_n;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk_int("bounce_R_first_low_edge", first_r, e0 + DB_CNT + 2);
    chk_int("bounce_R_low_cycles", r_low, PULSE_LEN);

    // A 3-cycle glitch is shorter than DB_CNT and must be filtered.
    clr();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk_int("glitch_S_low_cycles", s_low, 0);

    // Both buttons pressed in the same cycle.
    clr();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk_int("simul_conflict_cycles", conf_cnt, 1);
    chk_int("simul_busy_cycles", busy_cnt, 0);
    chk_int("simul_SR_low_cycles", s_low + r_low, 0);

    // A reset press that lands during a set pulse, then a fresh reset press.
    clr();
    step(1'b1, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    chk_int("overlap_dropped_cycles", drop_cnt, 1);
    chk_int("overlap_S_low_cycles", s_low, PULSE_LEN);
    chk_int("overlap_R_low_cycles", r_low, 0);
    clr();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk_int("after_guard_R_low_cycles", r_low, PULSE_LEN);

    // Reset asserted during a set pulse.
    clr();
    for (int i = 0; i < DB_CNT + 3; i++) step(1'b1, 1'b0);
    chk("midpulse_S_low_before_reset", bus.S, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    chk_int("midpulse_S_low_cycles", s_low, 1);

    // Random button activity with occasional resets.
    for (int seg = 0; seg < 80; seg++) begin
      sb  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        step(sb, rb);
        rst_n = 1'b1;
      end
      for (int i = 0; i < len; i++) step(sb, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
